// File: rtl/mem_responder_if.sv
// Processor memory bus plus program-loader byte stream.
// The processor core or the board-level program source drives the master side.
// mem_responder drives the slave side.
//   m_addr/m_data/m_rw : processor request.        m_q      : registered read data.
//   ld_start           : starts a load at address 0.
//   ld_valid/ld_data   : loader byte, high byte first, then low byte.
//   ld_last            : marks a low byte as the final word of the load.
//   ld_ready/ld_busy   : loader status.            ld_done  : end-of-load pulse.
//   ld_count           : number of words written by the current or most recent load.
interface mem_responder_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic              m_rw;
   logic [DATA_W-1:0] m_q;
   logic              ld_start;
   logic              ld_valid;
   logic [7:0]        ld_data;
   logic              ld_last;
   logic              ld_ready;
   logic              ld_busy;
   logic              ld_done;
   logic [ADDR_W:0]   ld_count;

   modport master (
      output m_addr, m_data, m_rw, ld_start, ld_valid, ld_data, ld_last,
      input  m_q, ld_ready, ld_busy, ld_done, ld_count
   );

   modport slave (
      input  m_addr, m_data, m_rw, ld_start, ld_valid, ld_data, ld_last,
      output m_q, ld_ready, ld_busy, ld_done, ld_count
   );
endinterface

// File: rtl/mem_responder.sv
// Responder end of the processor memory bus.
// It holds a DEPTH x DATA_W synchronous word memory with registered read data.
// It also contains a byte-stream loader that fills the memory from address 0
// before execution starts.
//   clock, reset : single clock; synchronous active-high reset.
//   bus (slave)  : processor port (m_addr/m_data/m_rw -> m_q) and loader port
//                  (ld_start/ld_valid/ld_data/ld_last -> ld_ready/ld_busy/ld_done/ld_count).
//
// Loader FSM
//   state     | meaning
//   S_IDLE    | no load; the processor owns the memory
//   S_LOAD_HI | waiting for the high byte of the next word
//   S_LOAD_LO | waiting for the low byte; writes the word when it arrives
//   S_LAST    | final word written; still busy, no bytes accepted
//   S_DONE    | ld_done pulse; busy released; returns to S_IDLE
module mem_responder #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4096
) (
   input logic            clock,
   input logic            reset,
   mem_responder_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_HI, S_LOAD_LO, S_LAST, S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [7:0]        hi_q, hi_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              ld_ready, ld_busy, ld_done;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         rdata_q <= rdata_d;
      end
   end

   // The array is not reset.
   // mem_we is already gated off on the reset edge.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ld_start) begin
               state_d = S_LOAD_HI;
               addr_d  = '0;
               cnt_d   = '0;
            end
         end
         S_LOAD_HI: begin
            if (bus.ld_valid) begin
               hi_d    = bus.ld_data;
               state_d = S_LOAD_LO;
            end
         end
         S_LOAD_LO: begin
            if (bus.ld_valid) begin
               addr_d  = addr_q + ADDR_ONE;
               cnt_d   = cnt_q + CNT_ONE;
               // The write to the top word ends the load, so addr_d never wraps into use.
               state_d = (bus.ld_last || addr_q == ADDR_LAST) ? S_LAST : S_LOAD_HI;
            end
         end
         S_LAST:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ld_ready = 1'b0;
      ld_busy  = 1'b0;
      ld_done  = 1'b0;
      case (state_q)
         S_LOAD_HI, S_LOAD_LO: begin
            ld_ready = 1'b1;
            ld_busy  = 1'b1;
         end
         S_LAST:  ld_busy = 1'b1;
         S_DONE:  ld_done = 1'b1;
         default: ;
      endcase

      // A single write port is enough.
      // The loader writes only while busy, and the processor writes only while not busy.
      mem_we    = 1'b0;
      mem_waddr = bus.m_addr;
      mem_wdata = bus.m_data;
      if (!reset) begin
         if (state_q == S_LOAD_LO && bus.ld_valid) begin
            mem_we    = 1'b1;
            mem_waddr = addr_q;
            mem_wdata = {hi_q, bus.ld_data};
         end else if (!ld_busy && bus.m_rw) begin
            mem_we = 1'b1;
         end
      end

      // The read samples the array before this edge's write, so a read-during-write returns the old data.
      rdata_d = ld_busy ? rdata_q : mem[bus.m_addr];
   end

   assign bus.m_q      = rdata_q;
   assign bus.ld_ready = ld_ready;
   assign bus.ld_busy  = ld_busy;
   assign bus.ld_done  = ld_done;
   assign bus.ld_count = cnt_q;
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
   logic clock;
   logic reset;

   mem_responder_if bus ();

   mem_responder dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Reference memory; ref_ok marks words with defined contents.
   logic [15:0] ref_mem [4096];
   bit          ref_ok  [4096];
   logic [7:0]  lb      [8192];

   initial begin
      #5_000_000;
      $display("FAIL timeout: run did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One processor cycle. m_q must show the word as it was before this edge.
   task automatic proc(input logic [11:0] a, input logic [15:0] d, input logic rw);
      bus.m_addr = a;
      bus.m_data = d;
      bus.m_rw   = rw;
      tick();
      if (ref_ok[a]) check("m_q", 32'(bus.m_q), 32'(ref_mem[a]));
      if (rw) begin
         ref_mem[a] = d;
         ref_ok[a]  = 1'b1;
      end
      bus.m_rw = 1'b0;
   endtask

   // Streams lb[0..nbytes-1] as one load.
   // Expected words come straight from byte pairs.
   // Expected busy time is the start cycle plus one cycle per byte or gap.
   task automatic do_load(input int nbytes, input bit use_last, input bit gaps, input bit disturb);
      int          busy_cnt;
      int          gap_cnt;
      int          g;
      bit          hold_ok;
      logic [15:0] hold_val;
      logic [11:0] saved_addr;
      busy_cnt   = 0;
      gap_cnt    = 0;
      saved_addr = bus.m_addr;
      hold_ok    = ref_ok[saved_addr];
      hold_val   = ref_mem[saved_addr];

      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      check("start_ready", 32'(bus.ld_ready), 32'd1);
      check("start_count", 32'(bus.ld_count), 32'd0);
      busy_cnt += int'(bus.ld_busy);

      for (int i = 0; i < nbytes; i++) begin
         g = 0;
         while ((gaps && g < 3 && $urandom_range(0, 2) == 0) || (disturb && i == 2 && g == 0)) begin
            bus.ld_valid = 1'b0;
            bus.ld_data  = 8'($urandom);
            if (disturb && i == 2 && g == 0) begin
               bus.m_rw   = 1'b1;
               bus.m_addr = 12'h100;
               bus.m_data = 16'hDEAD;
            end
            tick();
            bus.m_rw   = 1'b0;
            bus.m_addr = saved_addr;
            busy_cnt += int'(bus.ld_busy);
            gap_cnt++;
            g++;
         end
         bus.ld_valid = 1'b1;
         bus.ld_data  = lb[i];
         bus.ld_last  = use_last && (i == nbytes - 1);
         bus.ld_start = disturb && (i == 3);
         tick();
         bus.ld_start = 1'b0;
         busy_cnt += int'(bus.ld_busy);
      end

      // Keep ld_valid high with junk bytes; they must be dropped.
      bus.ld_last = 1'b0;
      bus.ld_data = 8'hEE;
      check("last_busy", 32'(bus.ld_busy), 32'd1);
      check("last_done", 32'(bus.ld_done), 32'd0);
      check("last_ready", 32'(bus.ld_ready), 32'd0);
      if (hold_ok) check("mq_hold", 32'(bus.m_q), 32'(hold_val));
      tick();
      check("done_pulse", 32'(bus.ld_done), 32'd1);
      check("done_busy", 32'(bus.ld_busy), 32'd0);
      check("ld_count", 32'(bus.ld_count), 32'(nbytes / 2));
      check("busy_cycles", 32'(busy_cnt), 32'(1 + nbytes + gap_cnt));
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      bus.ld_valid = 1'b0;
      check("done_clear", 32'(bus.ld_done), 32'd0);
      check("start_in_done", 32'(bus.ld_busy), 32'd0);
      check("count_hold", 32'(bus.ld_count), 32'(nbytes / 2));

      for (int w = 0; w < nbytes / 2; w++) begin
         ref_mem[w] = {lb[2*w], lb[2*w+1]};
         ref_ok[w]  = 1'b1;
      end
   endtask

   initial begin
      logic [7:0] three [6];
      int         nw;
      three = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

      reset        = 1'b1;
      bus.m_addr   = '0;
      bus.m_data   = '0;
      bus.m_rw     = 1'b0;
      bus.ld_start = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      bus.ld_last  = 1'b0;
      tick();
      tick();
      check("rst_m_q", 32'(bus.m_q), 32'd0);
      check("rst_ready", 32'(bus.ld_ready), 32'd0);
      check("rst_busy", 32'(bus.ld_busy), 32'd0);
      check("rst_done", 32'(bus.ld_done), 32'd0);
      check("rst_count", 32'(bus.ld_count), 32'd0);
      reset = 1'b0;

      // Processor read/write and read-during-write.
      proc(12'h005, 16'h1234, 1'b1);
      proc(12'h005, 16'h0000, 1'b0);
      check("rd_005", 32'(bus.m_q), 32'h1234);
      proc(12'h006, 16'h00AB, 1'b1);
      proc(12'h006, 16'h0000, 1'b0);
      check("rd_006", 32'(bus.m_q), 32'h00AB);
      proc(12'h010, 16'h1111, 1'b1);
      proc(12'h010, 16'h2222, 1'b1);
      check("rdw_old", 32'(bus.m_q), 32'h1111);
      proc(12'h010, 16'h0000, 1'b0);
      check("rdw_new", 32'(bus.m_q), 32'h2222);

      // No write on a reset edge.
      proc(12'h200, 16'h4242, 1'b1);
      bus.m_addr = 12'h200;
      bus.m_data = 16'hBEEF;
      bus.m_rw   = 1'b1;
      reset      = 1'b1;
      tick();
      reset    = 1'b0;
      bus.m_rw = 1'b0;
      check("rst_edge_mq", 32'(bus.m_q), 32'd0);
      proc(12'h200, 16'h0000, 1'b0);

      // Three-word load with ld_valid held high. Word 3 must stay untouched.
      proc(12'h003, 16'h3333, 1'b1);
      proc(12'h100, 16'h0100, 1'b1);
      proc(12'h005, 16'h0000, 1'b0);
      for (int i = 0; i < 6; i++) lb[i] = three[i];
      do_load(6, 1'b1, 1'b0, 1'b0);
      for (int a = 0; a < 4; a++) proc(12'(a), 16'h0000, 1'b0);
      check("w0", 32'(ref_mem[0]), 32'h1234);

      // Same bytes with random gaps.
      // A processor write and an ld_start are attempted during the load.
      proc(12'h005, 16'h0000, 1'b0);
      do_load(6, 1'b1, 1'b1, 1'b1);
      for (int a = 0; a < 4; a++) proc(12'(a), 16'h0000, 1'b0);
      proc(12'h100, 16'h0000, 1'b0);
      check("blocked_wr", 32'(bus.m_q), 32'h0100);

      // Random content, random length, random gaps.
      nw = $urandom_range(2, 6);
      for (int i = 0; i < 2 * nw; i++) lb[i] = 8'($urandom);
      proc(12'h006, 16'h0000, 1'b0);
      do_load(2 * nw, 1'b1, 1'b1, 1'b0);
      for (int a = 0; a < 7; a++) proc(12'(a), 16'h0000, 1'b0);

      // Full-depth load with no ld_last. It must end at the top word with no wrap.
      for (int i = 0; i < 8192; i++) lb[i] = 8'($urandom);
      proc(12'h005, 16'h0000, 1'b0);
      do_load(8192, 1'b0, 1'b0, 1'b0);
      proc(12'h000, 16'h0000, 1'b0);
      check("full_w0", 32'(bus.m_q), 32'({lb[0], lb[1]}));
      proc(12'hFFF, 16'h0000, 1'b0);
      check("full_top", 32'(bus.m_q), 32'({lb[8190], lb[8191]}));
      proc(12'h800, 16'h0000, 1'b0);
      proc(12'h001, 16'h0000, 1'b0);

      // Reset mid-load after the high byte of word 2.
      lb[0] = 8'hC0; lb[1] = 8'h01; lb[2] = 8'hC1; lb[3] = 8'h02; lb[4] = 8'hAA;
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = lb[i];
         tick();
      end
      bus.ld_valid = 1'b0;
      reset        = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_count", 32'(bus.ld_count), 32'd0);
      check("abort_busy", 32'(bus.ld_busy), 32'd0);
      check("abort_ready", 32'(bus.ld_ready), 32'd0);
      check("abort_m_q", 32'(bus.m_q), 32'd0);
      ref_mem[0] = 16'hC001; ref_mem[1] = 16'hC102;
      proc(12'h000, 16'h0000, 1'b0);
      proc(12'h001, 16'h0000, 1'b0);
      proc(12'h002, 16'h0000, 1'b0);

      // A fresh load starts at address 0.
      lb[0] = 8'h5A; lb[1] = 8'hC3;
      do_load(2, 1'b1, 1'b0, 1'b0);
      proc(12'h000, 16'h0000, 1'b0);
      check("reload_w0", 32'(bus.m_q), 32'h5AC3);
      proc(12'h001, 16'h0000, 1'b0);
      check("reload_w1", 32'(bus.m_q), 32'hC102);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
